// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for a 16-bit CR16-style datapath.
// Fetch and load-data waits are sized by MEM_LAT (BRAM read latency, 1..3).
// Optional macro CTRL_ILLEGAL_TRAP_EN: when defined, undefined instructions park
// the FSM in S_HALT until reset; otherwise they retire as a NOP.
module cpu_controller #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [1:0]  flags1out,
  input  logic [2:0]  flags2out,
  output logic        MemW1en,
  output logic        MemW2en,
  output logic        RFen,
  output logic        PSRen,
  output logic        PCen,
  output logic        INSTRen,
  output logic        Movm,
  output logic        A1m,
  output logic        setZNL,
  output logic [1:0]  PCm,
  output logic [1:0]  MAm,
  output logic [1:0]  A2m,
  output logic [1:0]  RWm,
  output logic [3:0]  aluOp,
  output logic        halted
);

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  typedef enum logic [3:0] {
    S_FETCH, S_LOADIR, S_DECODE, S_ALU, S_LDADDR,
    S_LDWB, S_STORE, S_JUMP, S_BRANCH, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    K_ALU, K_LUI, K_LOAD, K_STOR, K_JAL, K_JCOND, K_BCOND, K_ILL
  } kind_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  wire [3:0] op   = instr[15:12];
  wire [3:0] cond = instr[11:8];
  wire [3:0] ext  = instr[7:4];
  wire       unused_rtgt = ^instr[3:0];

  wire fC = flags1out[1];
  wire fF = flags1out[0];
  wire fZ = flags2out[2];
  wire fN = flags2out[1];
  wire fL = flags2out[0];

  kind_e      kind;
  logic [3:0] dec_alu;
  logic [1:0] dec_a2m;
  logic       dec_wr, dec_mov, dec_psr, dec_znl;
  logic [3:0] code;
  logic       taken;

  // Branch/jump condition, evaluated from live flags during the exec cycle.
  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = fZ;
      4'h1: taken = !fZ;
      4'h2: taken = fC;
      4'h3: taken = !fC;
      4'h4: taken = fL;
      4'h5: taken = !fL;
      4'h6: taken = fN;
      4'h7: taken = !fN;
      4'h8: taken = fF;
      4'h9: taken = !fF;
      4'hA: taken = !fL && !fZ;
      4'hB: taken = fL || fZ;
      4'hC: taken = !fN && !fZ;
      4'hD: taken = fN || fZ;
      4'hE: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Instruction decode: class plus the ALU-form controls. Reg-reg forms carry
  // the operation in ext; immediate forms carry the same code in the opcode.
  always_comb begin
    kind    = K_ILL;
    dec_alu = 4'd0;
    dec_a2m = 2'd0;
    dec_wr  = 1'b1;
    dec_mov = 1'b1;
    dec_psr = 1'b0;
    dec_znl = 1'b0;
    code    = (op == 4'h0) ? ext : op;
    if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
      dec_a2m = (op == 4'h0) ? 2'd0 : 2'd2;
      kind    = K_ALU;
      case (code)
        4'h5: begin dec_alu = 4'd0; dec_psr = 1'b1; end
        4'h9: begin dec_alu = 4'd1; dec_psr = 1'b1; end
        4'h1: dec_alu = 4'd2;
        4'h2: dec_alu = 4'd3;
        4'h3: dec_alu = 4'd4;
        4'hB: begin dec_alu = 4'd5; dec_psr = 1'b1; dec_znl = 1'b1; dec_wr = 1'b0; end
        4'hD: begin dec_alu = 4'd7; dec_mov = 1'b0; end
        default: kind = K_ILL;
      endcase
    end else begin
      case (op)
        4'h8: begin
          dec_alu = 4'd6;
          if (ext == 4'b0100) kind = K_ALU;
          else if (ext[3:1] == 3'b000) begin kind = K_ALU; dec_a2m = 2'd1; end
        end
        4'h4: begin
          case (ext)
            4'b0000: kind = K_LOAD;
            4'b0100: kind = K_STOR;
            4'b1000: kind = K_JAL;
            4'b1100: kind = K_JCOND;
            default: kind = K_ILL;
          endcase
        end
        4'hC:    kind = K_BCOND;
        4'hF:    kind = K_LUI;
        default: kind = K_ILL;
      endcase
    end
  end

  // State and wait-counter registers; reset lands in a fresh fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= LAT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore outputs; everything defaults low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    MemW1en = 1'b0;
    MemW2en = 1'b0;
    RFen    = 1'b0;
    PSRen   = 1'b0;
    PCen    = 1'b0;
    INSTRen = 1'b0;
    Movm    = 1'b0;
    A1m     = 1'b0;
    setZNL  = 1'b0;
    PCm     = 2'd0;
    MAm     = 2'd0;
    A2m     = 2'd0;
    RWm     = 2'd0;
    aluOp   = 4'd0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (cnt_q <= 2'd1) state_d = S_LOADIR;
        else cnt_d = cnt_q - 2'd1;
      end
      S_LOADIR: begin
        INSTRen = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (kind)
          K_ALU, K_LUI:    state_d = S_ALU;
          K_LOAD:          begin state_d = S_LDADDR; cnt_d = LAT; end
          K_STOR:          state_d = S_STORE;
          K_JAL, K_JCOND:  state_d = S_JUMP;
          K_BCOND:         state_d = S_BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:         state_d = S_HALT;
`else
          default:         state_d = S_ALU;
`endif
        endcase
      end
      S_ALU: begin
        PCen = 1'b1;
        if (kind == K_ALU) begin
          RWm    = 2'd2;
          Movm   = dec_mov;
          RFen   = dec_wr;
          PSRen  = dec_psr;
          setZNL = dec_znl;
          aluOp  = dec_alu;
          A2m    = dec_a2m;
        end else if (kind == K_LUI) begin
          RWm  = 2'd3;
          RFen = 1'b1;
        end
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
      S_LDADDR: begin
        MAm = 2'd1;
        if (cnt_q <= 2'd1) state_d = S_LDWB;
        else cnt_d = cnt_q - 2'd1;
      end
      S_LDWB: begin
        MAm     = 2'd1;
        RFen    = 1'b1;
        PCen    = 1'b1;
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
      S_STORE: begin
        MAm     = 2'd1;
        MemW1en = 1'b1;
        PCen    = 1'b1;
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
      S_JUMP: begin
        PCen = 1'b1;
        if (kind == K_JAL) begin
          RWm  = 2'd1;
          RFen = 1'b1;
          PCm  = 2'd1;
        end else begin
          PCm = taken ? 2'd1 : 2'd0;
        end
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
      S_BRANCH: begin
        PCen    = 1'b1;
        A1m     = 1'b1;
        A2m     = 2'd2;
        PCm     = taken ? 2'd2 : 2'd0;
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        halted = 1'b1;
      end
`endif
      default: begin
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
    endcase
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter: MEM_LAT, 1, BRAM read latency in cycles from address to q_a valid; legal values 1..3.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: instr  input  16  IR contents; [15:12] opcode, [11:8] Rsrc/cond, [7:4] ext, [3:0] Rdst/Rtgt.
REQ-005 SHALL have ports: flags1out  input  2  {C,F}; flags2out  input  3  {Z,N,L}.
REQ-006 SHALL have ports: MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen  output  1 each  datapath enables.
REQ-007 SHALL have ports: Movm, A1m, setZNL  output  1 each; PCm, MAm, A2m, RWm  output  2 each; aluOp  output  4.
REQ-008 SHALL have port: halted  output  1  high while in S_HALT.

Function
REQ-009 SHALL drive every output 0 in every state unless a state below names it; MemW2en SHALL be constant 0.
REQ-010 Mux codes SHALL be: PCm 0=PC+1,1=RFread2,2=aluOut; MAm 0=PC,1=RFread2; RWm 0=MemRead1,1=PC+1,2=MovMux,3=LUI immd; Movm 0=A2Mux,1=aluOut; A1m 0=RFread1,1=PC; A2m 0=RFread2,1=instr[3:0],2=sign-ext immd.
REQ-011 aluOp SHALL be: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 CMP,6 LSH,7 PASS.
REQ-012 S_FETCH: MAm=0; held MEM_LAT cycles via down-counter loaded on entry, then -> S_LOADIR.
REQ-013 S_LOADIR: MAm=0, INSTRen=1; -> S_DECODE.
REQ-014 S_DECODE: no outputs; -> exec state selected from instr per REQ-015..020.
REQ-015 Reg-reg (op 0000; ext 0101 ADD,1001 SUB,0001 AND,0010 OR,0011 XOR,1011 CMP,1101 MOV) and immediate (op = same ext code, A2m=2; op 1000 LSHI with A2m=1, ext 0100 under op 1000 = LSH reg) -> S_ALU: RWm=2, Movm=1 (0 for MOV/MOVI), RFen=1 (0 for CMP/CMPI), PSRen=1 for ADD/SUB/CMP forms, setZNL=1 for CMP forms only, PCen=1, PCm=0.
REQ-016 LUI (op 1111) -> S_ALU with RWm=3, RFen=1, PCen=1.
REQ-017 LOAD (op 0100, ext 0000) -> S_LDADDR: MAm=1, held MEM_LAT cycles; -> S_LDWB: MAm=1, RWm=0, RFen=1, PCen=1, PCm=0; -> S_FETCH.
REQ-018 STOR (op 0100, ext 0100) -> S_STORE: MAm=1, MemW1en=1, PCen=1, PCm=0; exactly one write cycle.
REQ-019 JAL (op 0100, ext 1000) -> S_JUMP: RWm=1, RFen=1, PCen=1, PCm=1. Jcond (op 0100, ext 1100) -> S_JUMP: PCen=1, PCm=taken?1:0, RFen=0.
REQ-020 Bcond (op 1100) -> S_BRANCH: PCen=1, A1m=1, A2m=2, aluOp=0, PCm=taken?2:0, PSRen=0.
REQ-021 Condition instr[11:8]: 0 Z,1 !Z,2 C,3 !C,4 L,5 !L,6 N,7 !N,8 F,9 !F,A !L&!Z,B L|Z,C !N&!Z,D N|Z,E always,F never; evaluated combinationally from flag inputs in the exec cycle.
REQ-022 All exec states SHALL return to S_FETCH next cycle; instruction latency: ALU/LUI/STOR/JAL/J/B = MEM_LAT+3 cycles, LOAD = 2*MEM_LAT+3.
REQ-023 Undefined opcode/ext combination: see REQ-027.

Reset
REQ-024 reset high SHALL immediately force S_FETCH, counter = MEM_LAT, halted=0, all outputs 0 (asynchronous).
REQ-025 reset asserted mid-instruction (incl. S_STORE) SHALL abort it; MemW1en, RFen, PCen SHALL fall the same instant.
REQ-026 After reset release, first PC fetch starts on next rising edge.

Configuration
REQ-027 Macro CTRL_ILLEGAL_TRAP_EN: defined -> undefined instruction SHALL enter S_HALT (halted=1, all enables 0) until reset; undefined -> treated as NOP (S_ALU with only PCen=1, PCm=0), halted tied 0.

Verification
REQ-028 Reset mid-S_LDADDR -> within same cycle all enables 0; next fetch after release with MAm=0.
REQ-029 instr=0x0153 (ADD), MEM_LAT=1 -> S_ALU 4th cycle: RFen=1, PSRen=1, Movm=1, RWm=2, aluOp=0, PCen=1.
REQ-030 instr=0x4102 (LOAD), MEM_LAT=2 -> MAm=1 two cycles, then RFen=1 RWm=0; total 7 cycles.
REQ-031 instr=0xC0FE (BEQ -2), Z=1 -> PCm=2, A1m=1, A2m=2; Z=0 -> PCm=0.
REQ-032 instr=0x41C5 (JNE), Z=0 -> PCm=1; instr=0x4E85 (JAL) -> RFen=1, RWm=1, PCm=1.
REQ-033 instr=0x00E3 with CTRL_ILLEGAL_TRAP_EN -> halted=1, no PCen thereafter; without -> PCen=1, PCm=0, RFen=0.
